note_sequence_writer: RTL and testbench

Generates the packed 8-note sequence consumed by the game engine, writes it with a one-cycle `write_enable` strobe and then issues `game_start`. It sits between the top-level control (start button, seed source) and the game engine's `data_in`/`write_enable`/`game_start`/`game_end` interface. Notes come from a 16-bit Galois LFSR, with a rule that forbids two consecutive equal notes. The block then waits for `game_end` and counts completed rounds.

---
 rtl/note_sequence_writer.sv | 138 +++++++++++++
 tb/tb_note_sequence_writer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequence_writer.sv
// Builds an 8-note LFSR sequence with no two adjacent notes equal, hands it to the
// game engine with a write strobe and a start strobe, then counts completed rounds.
module note_sequence_writer #(
   parameter int          GAP_CYCLES   = 2,
   parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        new_game,
   input  logic        abort,
   input  logic        seed_load,
   input  logic [15:0] seed_in,
   input  logic        game_end,
   output logic [31:0] data_out,
   output logic        write_enable,
   output logic        game_start,
   output logic        busy,
   output logic [6:0]  round_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_GEN, S_WRITE, S_GAP, S_START, S_PLAY, S_DONE
   } state_t;

   localparam int          GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
   localparam logic [3:0]  GAP_LAST   = GAP_LAST_I[3:0];

   state_t      r_state;
   state_t      w_state_next;
   logic [15:0] r_lfsr;
   logic [15:0] w_lfsr_next;
   logic [2:0]  r_idx;
   logic [2:0]  r_prev;
   logic [2:0]  w_raw;
   logic [2:0]  w_note;
   logic [31:0] r_shadow;
   logic [31:0] w_shadow_next;
   logic [31:0] r_data_out;
   logic [3:0]  r_gap;
   logic [6:0]  r_round;
   logic        r_ge;
   logic        r_ge_d;
   logic        w_ge_rise;

   assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
   assign w_raw       = w_lfsr_next[2:0];
   // Bump a repeated note by one (mod 8); the first note has no predecessor.
   assign w_note      = ((r_idx != 3'd0) && (w_raw == r_prev)) ? w_raw + 3'd1 : w_raw;
   assign w_ge_rise   = r_ge & ~r_ge_d;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_nib
         assign w_shadow_next[4*gi +: 4] = (r_idx == 3'(gi)) ? {1'b0, w_note}
                                                            : r_shadow[4*gi +: 4];
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= S_IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (new_game) w_state_next = S_GEN;
         S_GEN:   if (r_idx == 3'd7) w_state_next = S_WRITE;
         S_WRITE: w_state_next = (GAP_CYCLES == 0) ? S_START : S_GAP;
         S_GAP:   if (r_gap == GAP_LAST) w_state_next = S_START;
         S_START: w_state_next = S_PLAY;
         S_PLAY:  if (w_ge_rise) w_state_next = S_DONE;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
      if (abort)
         w_state_next = S_IDLE;
   end

   always_comb begin
      write_enable = 1'b0;
      game_start   = 1'b0;
      busy         = (r_state != S_IDLE);
      case (r_state)
         S_WRITE: write_enable = ~abort;
         S_START: game_start   = ~abort;
         default: ;
      endcase
   end

   // Abort freezes the whole datapath for that cycle, so LFSR and round count hold.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lfsr     <= SEED_DEFAULT;
         r_idx      <= 3'd0;
         r_prev     <= 3'd0;
         r_shadow   <= 32'h0;
         r_data_out <= 32'h0;
         r_gap      <= 4'd0;
         r_round    <= 7'd0;
         r_ge       <= 1'b0;
         r_ge_d     <= 1'b0;
      end else begin
         r_ge   <= game_end;
         r_ge_d <= r_ge;
         if (!abort) begin
            case (r_state)
               S_IDLE: begin
                  r_idx <= 3'd0;
                  if (seed_load)
                     r_lfsr <= (seed_in == 16'h0000) ? SEED_DEFAULT : seed_in;
               end
               S_GEN: begin
                  r_lfsr   <= w_lfsr_next;
                  r_prev   <= w_note;
                  r_shadow <= w_shadow_next;
                  r_idx    <= r_idx + 3'd1;
                  if (r_idx == 3'd7)
                     r_data_out <= w_shadow_next;
               end
               S_WRITE: r_gap <= 4'd0;
               S_GAP:   r_gap <= r_gap + 4'd1;
               S_DONE: begin
                  if (r_round != 7'd127)
                     r_round <= r_round + 7'd1;
               end
               default: ;
            endcase
         end
      end
   end

   assign data_out    = r_data_out;
   assign round_count = r_round;

endmodule

// File: tb/tb_note_sequence_writer.sv
// Scoreboard bench for note_sequence_writer: stimulus pushes predicted writes,
// a negedge monitor pops and compares them and checks strobe timing.
module tb_note_sequence_writer;
   localparam int GAP = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        new_game = 1'b0;
   logic        abort = 1'b0;
   logic        seed_load = 1'b0;
   logic [15:0] seed_in = 16'h0;
   logic        game_end = 1'b0;
   logic [31:0] data_out;
   logic        write_enable;
   logic        game_start;
   logic        busy;
   logic [6:0]  round_count;

   note_sequence_writer #(.GAP_CYCLES(GAP), .SEED_DEFAULT(16'hACE1)) dut (
      .clk(clk), .reset(reset), .new_game(new_game), .abort(abort),
      .seed_load(seed_load), .seed_in(seed_in), .game_end(game_end),
      .data_out(data_out), .write_enable(write_enable), .game_start(game_start),
      .busy(busy), .round_count(round_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [31:0] d;
      int          c;
   } exp_t;
   exp_t q[$];
   exp_t mon_e;

   bit          start_pending = 1'b0;
   int          we_cyc = 0;
   logic [15:0] m_lfsr = 16'hACE1;
   logic [31:0] m_data = 32'h0;
   int          m_rounds = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [15:0] m_step(input logic [15:0] s);
      return (s / 16'd2) ^ (s[0] ? 16'hB400 : 16'h0000);
   endfunction

   // Reference: 8 LFSR steps, low 3 bits as a note, a repeat of the previous note is bumped.
   task automatic model_gen(input logic [15:0] s_in, output logic [15:0] s_out,
                            output logic [31:0] d);
      logic [15:0] s;
      int prev;
      int raw;
      int note;
      s = s_in;
      prev = -1;
      d = 32'h0;
      for (int i = 0; i < 8; i++) begin
         s = m_step(s);
         raw = int'(s) % 8;
         note = (i > 0 && raw == prev) ? (raw + 1) % 8 : raw;
         d = d | (32'(note) << (4 * i));
         prev = note;
      end
      s_out = s;
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (write_enable || game_start)
            chk("we_gs_overlap", {31'b0, write_enable & game_start}, 32'h0);
         if (write_enable) begin
            int adj;
            $display("write cyc=%0d data_out=%h", cyc, data_out);
            if (q.size() == 0) begin
               chk("unexpected_write", 32'h1, 32'h0);
            end else begin
               mon_e = q.pop_front();
               chk("data_out", data_out, mon_e.d);
               chk("write_cycle", cyc, mon_e.c);
            end
            chk("pad_bits", data_out & 32'h88888888, 32'h0);
            adj = 0;
            for (int i = 0; i < 7; i++)
               if (data_out[4*i +: 4] == data_out[4*i+4 +: 4]) adj++;
            chk("adjacent_equal", adj, 32'h0);
            start_pending = 1'b1;
            we_cyc = cyc;
         end
         if (game_start) begin
            $display("start cyc=%0d", cyc);
            chk("start_expected", {31'b0, start_pending}, 32'h1);
            chk("start_cycle", cyc, we_cyc + GAP + 1);
            start_pending = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic start_game(input bit do_seed, input logic [15:0] seed,
                             input bit lit_en, input logic [31:0] lit);
      logic [15:0] s_out;
      logic [31:0] d;
      if (do_seed) begin
         seed_load = 1'b1;
         seed_in = seed;
         m_lfsr = (seed == 16'h0) ? 16'hACE1 : seed;
      end
      model_gen(m_lfsr, s_out, d);
      m_lfsr = s_out;
      if (lit_en) d = lit;
      q.push_back('{d: d, c: cyc + 9});
      m_data = d;
      new_game = 1'b1;
      tick();
      new_game = 1'b0;
      seed_load = 1'b0;
   endtask

   task automatic wait_gs();
      int n;
      n = 0;
      while (!game_start && n < 40) begin
         tick();
         n++;
      end
      chk("start_seen", {31'b0, game_start}, 32'h1);
   endtask

   task automatic end_round();
      game_end = 1'b1;
      ticks(2);
      chk("busy_in_done", {31'b0, busy}, 32'h1);
      tick();
      chk("busy_after_done", {31'b0, busy}, 32'h0);
      if (m_rounds < 127) m_rounds++;
      chk("round_count", round_count, m_rounds);
      game_end = 1'b0;
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] rs;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_data_out", data_out, 32'h0);
      chk("rst_write_enable", {31'b0, write_enable}, 32'h0);
      chk("rst_game_start", {31'b0, game_start}, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_round_count", round_count, 32'h0);
      reset = 1'b0;
      tick();

      // Default seed, full round ending 50 cycles after START.
      start_game(1'b0, 16'h0, 1'b1, 32'h41376410);
      chk("busy_rise", {31'b0, busy}, 32'h1);
      wait_gs();
      ticks(50);
      chk("busy_in_play", {31'b0, busy}, 32'h1);
      end_round();

      // game_end already high when PLAY starts must not end the round.
      game_end = 1'b1;
      ticks(3);
      chk("edge_outside_play", round_count, m_rounds);
      start_game(1'b0, 16'h0, 1'b0, 32'h0);
      wait_gs();
      ticks(20);
      chk("play_holds_high", {31'b0, busy}, 32'h1);
      game_end = 1'b0;
      ticks(3);
      chk("play_holds_low", {31'b0, busy}, 32'h1);
      end_round();

      // new_game / seed_load during PLAY are ignored; next round proves LFSR untouched.
      start_game(1'b0, 16'h0, 1'b0, 32'h0);
      wait_gs();
      ticks(2);
      new_game = 1'b1;
      seed_load = 1'b1;
      seed_in = 16'h1234;
      tick();
      new_game = 1'b0;
      seed_load = 1'b0;
      ticks(12);
      chk("ignore_in_play", {31'b0, busy}, 32'h1);
      end_round();
      start_game(1'b0, 16'h0, 1'b0, 32'h0);
      wait_gs();
      end_round();

      // Zero seed falls back to the default seed.
      seed_load = 1'b1;
      seed_in = 16'h0;
      tick();
      seed_load = 1'b0;
      m_lfsr = 16'hACE1;
      start_game(1'b0, 16'h0, 1'b1, 32'h41376410);
      wait_gs();
      end_round();

      // Abort during GEN at note 3: three LFSR steps consumed, nothing written.
      new_game = 1'b1;
      tick();
      new_game = 1'b0;
      ticks(3);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      m_lfsr = m_step(m_step(m_step(m_lfsr)));
      chk("abort_busy", {31'b0, busy}, 32'h0);
      chk("abort_data_out", data_out, m_data);
      ticks(12);
      start_game(1'b0, 16'h0, 1'b0, 32'h0);
      wait_gs();
      end_round();

      // Random seeds loaded together with new_game.
      for (int i = 0; i < 200; i++) begin
         rs = 16'($urandom_range(0, 65535));
         start_game(1'b1, rs, 1'b0, 32'h0);
         wait_gs();
         ticks($urandom_range(1, 4));
         if (i % 5 == 0) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            chk("abort_play_busy", {31'b0, busy}, 32'h0);
            chk("abort_play_rounds", round_count, m_rounds);
         end else begin
            end_round();
         end
      end

      // Reset during GAP: everything clears at once and no START follows.
      start_game(1'b0, 16'h0, 1'b0, 32'h0);
      ticks(9);
      start_pending = 1'b0;
      reset = 1'b1;
      #1;
      chk("gap_rst_write_enable", {31'b0, write_enable}, 32'h0);
      chk("gap_rst_game_start", {31'b0, game_start}, 32'h0);
      chk("gap_rst_data_out", data_out, 32'h0);
      chk("gap_rst_busy", {31'b0, busy}, 32'h0);
      chk("gap_rst_round_count", round_count, 32'h0);
      m_lfsr = 16'hACE1;
      m_data = 32'h0;
      m_rounds = 0;
      ticks(3);
      reset = 1'b0;
      ticks(20);
      start_game(1'b0, 16'h0, 1'b1, 32'h41376410);
      wait_gs();
      end_round();

      ticks(5);
      chk("pending_writes", q.size(), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
